// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one uart_tx serializer among NUM_REQ sources.
// Grants one byte per frame and times the frame itself (the serializer has no done flag).
module uart_tx_sched #(
    parameter  int NUM_REQ      = 4,
    parameter  int CLKS_PER_BIT = 868,
    parameter  int GAP_CYCLES   = 2,
    localparam int IW           = $clog2(NUM_REQ),
    localparam int FRAME_CYCLES = 10 * CLKS_PER_BIT + GAP_CYCLES,
    localparam int CW           = $clog2(FRAME_CYCLES)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx_active,
    output logic [7:0]           data,
    output logic                 busy,
    output logic [IW-1:0]        grant_id
);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT
    } state_t;

    state_t               state;
    state_t               state_n;
    logic [CW-1:0]        cnt;
    logic [CW-1:0]        cnt_n;
    logic [IW-1:0]        ptr;
    logic [IW-1:0]        ptr_n;
    logic [NUM_REQ-1:0]   ready_n;
    logic                 txa_n;
    logic [7:0]           data_n;
    logic                 busy_n;
    logic [IW-1:0]        gid_n;
    logic                 found;
    logic [IW-1:0]        win;

    // Index arithmetic modulo NUM_REQ (NUM_REQ need not be a power of two).
    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] a, input int k);
        int s;
        s = int'(a) + k;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return IW'(s);
    endfunction

    // First valid source scanning upward from the round-robin pointer.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req_valid[wrap_add(ptr, k)]) begin
                found = 1'b1;
                win   = wrap_add(ptr, k);
            end
        end
    end

    // Next-state and registered-output values for the frame FSM.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        ptr_n   = ptr;
        ready_n = '0;
        txa_n   = 1'b0;
        data_n  = data;
        busy_n  = busy;
        gid_n   = grant_id;
        unique case (state)
            IDLE: begin
                if (found) begin
                    data_n  = req_data[8*int'(win) +: 8];
                    gid_n   = win;
                    ready_n = NUM_REQ'(1) << win;
                    txa_n   = 1'b1;
                    busy_n  = 1'b1;
                    ptr_n   = wrap_add(win, 1);
                    state_n = LAUNCH;
                end
            end
            LAUNCH: begin
                cnt_n   = CW'(FRAME_CYCLES - 2);
                state_n = WAIT;
            end
            WAIT: begin
                if (cnt == '0) begin
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and output registers; reset abandons any frame in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            ptr       <= '0;
            req_ready <= '0;
            tx_active <= 1'b0;
            data      <= 8'h00;
            busy      <= 1'b0;
            grant_id  <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            ptr       <= ptr_n;
            req_ready <= ready_n;
            tx_active <= txa_n;
            data      <= data_n;
            busy      <= busy_n;
            grant_id  <= gid_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: vector table, directed corner
// sequences and randomized traffic against a countdown/pointer reference model.
module tb_uart_tx_sched;

    localparam int N     = 4;
    localparam int CPB   = 4;
    localparam int GAP   = 2;
    localparam int FRAME = 10 * CPB + GAP;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]   req_ready;
    logic           tx_active;
    logic [7:0]     data;
    logic           busy;
    logic [1:0]     grant_id;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // reference model state
    int           m_left = 0;
    int           m_ptr = 0;
    int           m_gid = 0;
    logic [7:0]   m_data = 8'h00;
    logic [N-1:0] m_ready = '0;
    logic         m_txa = 1'b0;

    // clock generation
    always #5 clk = ~clk;

    uart_tx_sched #(
        .NUM_REQ     (N),
        .CLKS_PER_BIT(CPB),
        .GAP_CYCLES  (GAP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_data (req_data),
        .req_ready(req_ready),
        .tx_active(tx_active),
        .data     (data),
        .busy     (busy),
        .grant_id (grant_id)
    );

    typedef struct {
        logic       r;
        logic [3:0] v;
        logic [3:0] ready;
        logic       txa;
        logic       bz;
        logic [1:0] gid;
        logic [7:0] d;
    } vec_t;

    vec_t tbl[6];

    task automatic model_step();
        bit found;
        m_ready = '0;
        m_txa   = 1'b0;
        if (!rst) begin
            m_left = 0;
            m_ptr  = 0;
            m_gid  = 0;
            m_data = 8'h00;
        end else if (m_left > 0) begin
            m_left--;
        end else begin
            found = 0;
            for (int k = 0; k < N; k++) begin
                int i;
                i = (m_ptr + k) % N;
                if (!found && req_valid[i]) begin
                    found     = 1;
                    m_gid     = i;
                    m_data    = req_data[8*i +: 8];
                    m_ready[i] = 1'b1;
                    m_txa     = 1'b1;
                    m_left    = FRAME;
                    m_ptr     = (i + 1) % N;
                end
            end
        end
    endtask

    task automatic check_cycle();
        checks++;
        if (req_ready !== m_ready || tx_active !== m_txa ||
            busy !== (m_left > 0) || grant_id !== 2'(m_gid) ||
            data !== m_data) begin
            failures++;
            $display("FAIL model cyc=%0d ready=%b/%b txa=%b/%b busy=%b/%b gid=%0d/%0d data=%h/%h (actual/required)",
                     cyc, req_ready, m_ready, tx_active, m_txa,
                     busy, (m_left > 0), grant_id, m_gid, data, m_data);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        cyc++;
        #1;
        check_cycle();
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Tick until the DUT pulses tx_active; n = ticks taken, g = grant seen.
    task automatic run_until_launch(input int budget, input bit drop,
                                    output int g, output int n);
        n = 0;
        g = -1;
        while (n < budget) begin
            tick();
            n++;
            if (tx_active === 1'b1) begin
                g = int'(grant_id);
                if (drop) req_valid = req_valid & ~req_ready;
                return;
            end
        end
        checks++;
        failures++;
        $display("FAIL launch_timeout actual=none required=tx_active within %0d", budget);
    endtask

    task automatic run_until_idle(input int budget);
        int n;
        n = 0;
        while (m_left > 0 && n < budget) begin
            tick();
            n++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        int n;
        int k;
        logic [7:0] dv;
        int bits[10];
        int exp_tx[10];

        exp_tx = '{0, 1, 0, 0, 0, 0, 0, 1, 0, 1};

        // reset and first grant
        tbl[0] = '{1'b0, 4'hF, 4'b0000, 1'b0, 1'b0, 2'd0, 8'h00};
        tbl[1] = '{1'b0, 4'hF, 4'b0000, 1'b0, 1'b0, 2'd0, 8'h00};
        tbl[2] = '{1'b0, 4'hF, 4'b0000, 1'b0, 1'b0, 2'd0, 8'h00};
        tbl[3] = '{1'b1, 4'hF, 4'b0001, 1'b1, 1'b1, 2'd0, 8'h10};
        tbl[4] = '{1'b1, 4'hE, 4'b0000, 1'b0, 1'b1, 2'd0, 8'h10};
        tbl[5] = '{1'b1, 4'h0, 4'b0000, 1'b0, 1'b1, 2'd0, 8'h10};
        req_data = 32'h13121110;
        for (int i = 0; i < 6; i++) begin
            rst       = tbl[i].r;
            req_valid = tbl[i].v;
            tick();
            chk($sformatf("vec%0d", i),
                {16'h0, req_ready, tx_active, busy, grant_id, data},
                {16'h0, tbl[i].ready, tbl[i].txa, tbl[i].bz, tbl[i].gid, tbl[i].d});
        end
        run_until_idle(60);
        tick();

        // single byte from source 2, frame length and serialized bits
        req_data[23:16] = 8'h41;
        req_valid = 4'b0100;
        run_until_launch(5, 1, g, n);
        chk("t2_gid", g, 2);
        chk("t2_ready", req_ready, 4'b0100);
        for (int c = 0; c < FRAME; c++) begin
            if (c > 0) tick();
            chk("t2_frame", {busy, grant_id, data}, {1'b1, 2'd2, 8'h41});
            if (c % CPB == 2) begin
                k = c / CPB;
                dv = data;
                if (k == 0) bits[k] = 0;
                else if (k == 9) bits[k] = 1;
                else bits[k] = int'(dv[k-1]);
            end
        end
        tick();
        chk("t2_busy_end", busy, 0);
        for (int b = 0; b < 10; b++) chk($sformatf("t2_tx_bit%0d", b), bits[b], exp_tx[b]);

        // round-robin under continuous demand
        rst = 1'b0;
        req_valid = '0;
        tick();
        rst = 1'b1;
        req_data = 32'h13121110;
        req_valid = 4'hF;
        for (int i = 0; i < 5; i++) begin
            run_until_launch(60, 0, g, n);
            chk("t3_gid", g, i % N);
            chk("t3_data", data, 8'h10 + 8'(i % N));
            if (i > 0) chk("t3_spacing", n, FRAME + 1);
        end
        req_valid = '0;
        run_until_idle(60);

        // pointer wrap and skip
        rst = 1'b0;
        tick();
        rst = 1'b1;
        req_valid = 4'b1000;
        run_until_launch(5, 1, g, n);
        chk("t4_first", g, 3);
        req_valid = req_valid | 4'b0110;
        run_until_launch(60, 1, g, n);
        chk("t4_second", g, 1);
        run_until_launch(60, 1, g, n);
        chk("t4_third", g, 2);
        req_valid = req_valid | 4'b0001;
        run_until_launch(60, 1, g, n);
        chk("t4_late0", g, 0);
        run_until_idle(60);

        // request arriving during WAIT
        req_valid = 4'b1000;
        run_until_launch(5, 1, g, n);
        chk("t5_first", g, 3);
        for (int i = 0; i < 10; i++) tick();
        req_valid = 4'b0010;
        k = 10;
        while (busy === 1'b1 && k < 60) begin
            chk("t5_no_ready", req_ready, 0);
            tick();
            k++;
        end
        chk("t5_busy_len", k, FRAME);
        tick();
        chk("t5_launch", {tx_active, req_ready, grant_id}, {1'b1, 4'b0010, 2'd1});
        req_valid = req_valid & ~req_ready;
        run_until_idle(60);

        // mid-frame reset
        req_valid = 4'b0010;
        run_until_launch(5, 1, g, n);
        chk("t6_first", g, 1);
        for (int i = 0; i < 20; i++) tick();
        req_valid = 4'b1001;
        rst = 1'b0;
        tick();
        chk("t6_reset", {req_ready, tx_active, busy, grant_id, data}, 16'h0);
        rst = 1'b1;
        run_until_launch(5, 1, g, n);
        chk("t6_rearb", g, 0);
        run_until_launch(60, 1, g, n);
        chk("t6_then3", g, 3);
        run_until_idle(60);

        // randomized traffic against the model
        for (int t = 0; t < 4000; t++) begin
            tick();
            rst = ($urandom_range(0, 699) == 0) ? 1'b0 : 1'b1;
            for (int i = 0; i < N; i++) begin
                if (m_ready[i]) begin
                    if ($urandom_range(0, 1) == 0) req_valid[i] = 1'b0;
                    else req_data[8*i +: 8] = 8'($urandom);
                end else if (!req_valid[i]) begin
                    if ($urandom_range(0, 5) == 0) begin
                        req_valid[i] = 1'b1;
                        req_data[8*i +: 8] = 8'($urandom);
                    end
                end else if ($urandom_range(0, 49) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Round-robin scheduler that shares one `uart_tx` serializer among `NUM_REQ` byte sources. Each source offers a byte with a valid/ready handshake. The scheduler grants one source per frame, drives the serializer's `data` and a one-cycle `tx_active` launch pulse, and times the frame internally because the serializer has no done flag. It sits directly between the requesting blocks and `uart_tx`, and shares `clk`/`rst` with it.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `CLKS_PER_BIT`, 868: serializer clocks per bit; must match the `uart_tx` instance.
- `GAP_CYCLES`, 2: idle cycles appended after each 10-bit frame (start + 8 data + stop).
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `req_valid`  in  NUM_REQ  per-source byte offered; held until accepted.
- `req_data`  in  8*NUM_REQ  byte for source i at bits [8i+7:8i].
- `req_ready`  out  NUM_REQ  one-hot, one-cycle accept pulse.
- `tx_active`  out  1  launch pulse to `uart_tx`.
- `data`  out  8  byte to `uart_tx`; stable for the whole frame.
- `busy`  out  1  high from launch through end of gap.
- `grant_id`  out  clog2(NUM_REQ)  index of the source currently/last served.

## Operation
- FRAME_CYCLES = 10*CLKS_PER_BIT + GAP_CYCLES.
- Frame counter width is clog2(FRAME_CYCLES).
- Reset (`rst`=0 at an edge):
  - `req_ready`=0, `tx_active`=0, `data`=8'h00, `busy`=0, `grant_id`=0.
  - State IDLE, counter 0, round-robin pointer 0 (source 0 highest priority).
- Reset mid-frame abandons the frame; `uart_tx` shares `rst` and is reset too. Accepted-but-unfinished bytes are lost.
- State IDLE:
  - If any `req_valid` bit is set, select winner g as the first set bit scanning from the pointer upward, wrapping modulo NUM_REQ.
  - Register `data`<=req_data[g], `grant_id`<=g, `req_ready[g]`<=1, `tx_active`<=1, `busy`<=1.
  - Pointer <= (g+1) mod NUM_REQ. Go to LAUNCH.
- State LAUNCH (one cycle; `tx_active`=1, `req_ready[g]`=1 visible):
  - Next edge: clear `tx_active` and `req_ready`, load counter with FRAME_CYCLES-2, go to WAIT.
- State WAIT:
  - Decrement the counter each cycle.
  - When the counter is 0: `busy`<=0, go to IDLE.
  - `req_valid` is ignored; no `req_ready` is issued.
- `data` and `grant_id` hold their last values in IDLE; `data` never changes while `busy`=1.
- Source 0 is never starved: with all sources valid, grants go 0,1,2,3,0,...
- A source that drops `req_valid` before acceptance is simply skipped. Withdrawal is legal; the scheduler does not require valid to stay high.
- Requester rule: `req_data` must be stable while `req_valid` is high. The byte is sampled on the IDLE->LAUNCH edge.

## Timing
- Launch latency: `req_valid` high at edge E (in IDLE) -> `tx_active`, `req_ready[g]` and `busy` high in the cycle after E, for exactly 1 cycle.
- The requester sees `req_ready` in that cycle and must deassert `req_valid` (or present the next byte) at the following edge.
- `busy` is high for exactly FRAME_CYCLES cycles, starting with the `tx_active` cycle.
- Back-to-back: with continuous demand, `tx_active` pulses are exactly FRAME_CYCLES+1 cycles apart (one IDLE arbitration cycle).
- Simultaneous requests at the same edge are resolved by the pointer only; there is no fixed priority beyond reset.
- A request arriving during WAIT, or in the cycle `busy` falls, is served at the first IDLE edge.

## Test plan
Sim parameters: CLKS_PER_BIT=4, GAP_CYCLES=2, NUM_REQ=4, FRAME_CYCLES=42.

1. **Reset values:** hold `rst`=0 for 3 cycles with all `req_valid`=1 -> all outputs 0, no `tx_active`. Release -> first grant is source 0.
2. **Single byte:** source 2 offers 8'h41 ('A') -> one cycle later `tx_active`=1 and `req_ready`=4'b0100. Then `data`=8'h41 and `grant_id`=2 hold, `busy` is high for 42 cycles, and the `tx` line shows 0,1,0,0,0,0,0,1,0,1 at 4 clocks per bit.
3. **Round-robin:** all four sources valid continuously with bytes 8'h10..8'h13 -> grant order 0,1,2,3,0, and `tx_active` pulses are 43 cycles apart.
4. **Pointer wrap / skip:** after a grant to 3, only sources 1 and 2 valid -> 1 is served, then 2. Source 0 becomes valid late -> it is served after 2.
5. **Request during WAIT:** source 1 asserts valid 10 cycles into a frame -> no `req_ready` until `busy` falls, then launch one cycle after the IDLE edge.
6. **Mid-frame reset:** `rst`=0 at frame cycle 20 -> at the next edge `busy`=0, `data`=0, pointer 0. A pending request from source 3 is re-arbitrated from source 0 after release.
